rpn_engine: RTL and testbench
=============================

# rpn_engine

Reverse-Polish command engine sitting directly in front of the 4-bit LIFO `stack`. It accepts one command at a time and drives the stack's `push`, `pop` and `data_in` ports. It consumes `data_out`, `full` and `empty` to perform push, binary ALU, drop and clear operations. Results are written back onto the stack; the last result, flags and stack depth are also exported to the display/top level.

## Interface
- `WIDTH`, default 4: data width; matches stack word width.
- `DEPTH`, default 5: stack capacity in entries; matches stack depth.
- `DW`, default `$clog2(DEPTH+1)`: width of the depth counter.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rstN`  in  1  asynchronous, active-low reset. Tied to the same net as the stack's `rstN`.
- `cmd_valid`  in  1  command present.
- `cmd_op`  in  3  opcode: 000 PUSH, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 DROP, 111 CLEAR.
- `cmd_data`  in  WIDTH  operand for PUSH; ignored otherwise.
- `cmd_ready`  out  1  high only in IDLE; a command is accepted when `cmd_valid && cmd_ready`.
- `stk_push`  out  1  to stack `push`.
- `stk_pop`  out  1  to stack `pop`.
- `stk_din`  out  WIDTH  to stack `data_in`.
- `stk_dout`  in  WIDTH  from stack `data_out`.
- `stk_full`  in  1  from stack `full`.
- `stk_empty`  in  1  from stack `empty`.
- `result`  out  WIDTH  last value pushed by the engine.
- `carry`  out  1  ADD carry-out / SUB borrow of the last ALU op.
- `depth`  out  DW  engine's count of stack entries.
- `done`  out  1  one-cycle pulse when a command completes.
- `err`  out  1  one-cycle pulse when a command is rejected.
- `err_code`  out  2  00 none, 01 overflow, 10 underflow, 11 desync. Held until the next accepted command.

## Operation
- Stack contract:
  - `pop` asserted in cycle N makes the old top visible on `stk_dout` in cycle N+1.
  - `push` writes `data_in` on the edge.
  - The engine never asserts `stk_push` and `stk_pop` in the same cycle.
- FSM states: IDLE, PUSH_R, POP_B, POP_A, CAP_A, CLR.
- IDLE, on accept, checks guards in order:
  - Desync: (`depth==0` and `!stk_empty`) or (`depth==DEPTH` and `!stk_full`). Reject with code 11.
  - PUSH with `depth==DEPTH`: reject with code 01.
  - Binary op with `depth<2`: reject with code 10.
  - DROP with `depth==0`: reject with code 10.
  - CLEAR with `depth==0`: `done` next cycle, no stack traffic.
  - On any reject: `err` pulses the cycle after accept, state stays IDLE, no stack strobe.
- PUSH: latch `cmd_data` → PUSH_R. PUSH_R asserts `stk_push` with `stk_din`=operand, sets `result`, increments `depth`, pulses `done` → IDLE.
- Binary op:
  - POP_B: assert `stk_pop`, decrement `depth`.
  - POP_A: assert `stk_pop`, capture b=`stk_dout`, decrement `depth`.
  - CAP_A: capture a=`stk_dout`, compute a op b.
  - PUSH_R: push the result.
- ALU rules:
  - ADD: `{carry,r}` = a+b, computed at WIDTH+1 bits.
  - SUB: r = (a−b) mod 2^WIDTH; `carry` = (a<b).
  - Logic ops leave `carry` unchanged.
  - Operand order: a is the deeper entry, b the top.
- DROP: one `stk_pop` cycle, decrement `depth`, `done` in that cycle. `result` is unchanged.
- CLEAR: CLR asserts `stk_pop` for exactly `depth` consecutive cycles. `done` pulses in the final pop cycle, then `depth`=0.
- `cmd_valid` while not in IDLE is ignored; commands are not queued.

## Timing
- Reset: state IDLE; `cmd_ready`=1; all other outputs 0 (`stk_push`, `stk_pop`, `stk_din`, `result`, `carry`, `depth`, `done`, `err`, `err_code`).
- Reset asserted mid-command aborts immediately: state IDLE, no further strobes. The stack is cleared by the same reset, so `depth`=0 stays consistent.
- Latency from the accept edge to `done`:
  - PUSH: 1 cycle.
  - DROP: 1 cycle.
  - Binary op: 4 cycles.
  - CLEAR: `depth` cycles.
- Latency from the accept edge to `err`: 1 cycle.
- `cmd_ready` is low from the cycle after accept until the cycle after `done`/`err`.
- Back-to-back throughput: PUSH one per 2 cycles; binary op one per 5 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `rpn_pkg` holds:
  - Opcode localparams (`OP_PUSH`…`OP_CLEAR`).
  - Error codes (`ERR_NONE`, `ERR_OVF`, `ERR_UNF`, `ERR_DSYNC`).
  - FSM state encoding.
- Sub-module `rpn_alu`: purely combinational; inputs a, b, op; outputs r, carry_out, carry_we.
- Top-level test wrapper `rpn_top` instantiates `rpn_engine` plus `stack`.

## Test plan
- Reset: hold `rstN`=0 → all outputs 0 and `cmd_ready`=1; after release, `stk_push`/`stk_pop` stay 0 with no command.
- Add with carry: PUSH 9, PUSH 8, ADD → `result`=1, `carry`=1, `depth`=1; `done` 4 cycles after ADD accept; stack top reads 1.
- Subtract order/borrow: PUSH 3, PUSH 5, SUB → `result`=14, `carry`=1. Then PUSH 2, XOR → `result`=12, `carry` unchanged at 1.
- Underflow: after reset, PUSH 7, ADD → `err` pulse, `err_code`=10, `depth`=1, no `stk_pop` cycle; then DROP → `depth`=0.
- Overflow: push 1,2,3,4,5, then PUSH 6 → `err_code`=01, `depth`=5, no `stk_push`. Then CLEAR → exactly 5 `stk_pop` cycles, `depth`=0, `stk_empty`=1.
- Reset mid-op: PUSH 4, PUSH 4, ADD; drop `rstN` during POP_A → IDLE, `depth`=0. The next PUSH 14 → `result`=14, `depth`=1.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared opcodes, error codes and FSM encoding for the RPN command engine.
package rpn_pkg;

  localparam logic [2:0] OP_PUSH  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_XOR   = 3'b101;
  localparam logic [2:0] OP_DROP  = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_OVF   = 2'b01;
  localparam logic [1:0] ERR_UNF   = 2'b10;
  localparam logic [1:0] ERR_DSYNC = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH_R,
    S_POP_B,
    S_POP_A,
    S_CAP_A,
    S_CLR
  } state_t;

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU: r = a op b, where a is the deeper stack entry and b the top.
// Only ADD/SUB update carry (carry_we); logic ops leave it untouched.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] r,
  output logic             carry_out,
  output logic             carry_we
);

  logic [WIDTH:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    r         = '0;
    carry_out = 1'b0;
    carry_we  = 1'b0;
    case (op)
      OP_ADD: begin
        r         = sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
        carry_we  = 1'b1;
      end
      OP_SUB: begin
        r         = a - b;
        carry_out = (a < b);
        carry_we  = 1'b1;
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/rpn_engine.sv
// Reverse-Polish command engine driving a registered-output LIFO stack.
// One command at a time; all outputs registered; cmd_ready low while a command runs.
module rpn_engine
  import rpn_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 5,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             cmd_ready,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  input  logic             stk_full,
  input  logic             stk_empty,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic [DW-1:0]    depth,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam logic [DW-1:0] DMAX = DW'(DEPTH);
  localparam logic [DW-1:0] ONE  = DW'(1);
  localparam logic [DW-1:0] TWO  = DW'(2);

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_cwe;
  logic             dsync;

  assign dsync = ((depth == '0) && !stk_empty) || ((depth == DMAX) && !stk_full);

  // a arrives on stk_dout in CAP_A, one cycle after its pop
  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .a         (stk_dout),
    .b         (b_q),
    .op        (op_q),
    .r         (alu_r),
    .carry_out (alu_c),
    .carry_we  (alu_cwe)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      op_q      <= '0;
      b_q       <= '0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_din   <= '0;
      result    <= '0;
      carry     <= 1'b0;
      depth     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      case (state)
        S_IDLE: begin
          // ready drops for the done/err cycle of single-cycle outcomes
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_q      <= cmd_op;
            err_code  <= ERR_NONE;
            if (dsync) begin
              err      <= 1'b1;
              err_code <= ERR_DSYNC;
            end else begin
              case (cmd_op)
                OP_PUSH: begin
                  if (depth == DMAX) begin
                    err      <= 1'b1;
                    err_code <= ERR_OVF;
                  end else begin
                    stk_push <= 1'b1;
                    stk_din  <= cmd_data;
                    result   <= cmd_data;
                    depth    <= depth + ONE;
                    done     <= 1'b1;
                    state    <= S_PUSH_R;
                  end
                end
                OP_DROP: begin
                  if (depth == '0) begin
                    err      <= 1'b1;
                    err_code <= ERR_UNF;
                  end else begin
                    stk_pop <= 1'b1;
                    depth   <= depth - ONE;
                    done    <= 1'b1;
                    state   <= S_CLR;
                  end
                end
                OP_CLEAR: begin
                  if (depth == '0) begin
                    done <= 1'b1;
                  end else begin
                    stk_pop <= 1'b1;
                    depth   <= depth - ONE;
                    done    <= (depth == ONE);
                    state   <= S_CLR;
                  end
                end
                default: begin
                  if (depth < TWO) begin
                    err      <= 1'b1;
                    err_code <= ERR_UNF;
                  end else begin
                    stk_pop <= 1'b1;
                    depth   <= depth - ONE;
                    state   <= S_POP_B;
                  end
                end
              endcase
            end
          end
        end
        S_PUSH_R: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
        S_POP_B: begin
          stk_pop <= 1'b1;
          depth   <= depth - ONE;
          state   <= S_POP_A;
        end
        S_POP_A: begin
          b_q   <= stk_dout;
          state <= S_CAP_A;
        end
        S_CAP_A: begin
          result   <= alu_r;
          stk_din  <= alu_r;
          stk_push <= 1'b1;
          depth    <= depth + ONE;
          done     <= 1'b1;
          if (alu_cwe) carry <= alu_c;
          state    <= S_PUSH_R;
        end
        S_CLR: begin
          // done marks the final pop (DROP sets it on entry)
          if (done) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
          end else begin
            stk_pop <= 1'b1;
            depth   <= depth - ONE;
            done    <= (depth == ONE);
          end
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_engine.sv
// Bench for rpn_engine: behavioural 5-entry stack plus a table of commands with hand-computed results.
module tb_rpn_engine;
  import rpn_pkg::*;

  logic       clk = 1'b0;
  logic       rstN;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic       cmd_ready;
  logic       stk_push, stk_pop;
  logic [3:0] stk_din;
  logic [3:0] sdout;
  logic       stk_full, stk_empty;
  logic [3:0] result;
  logic       carry;
  logic [2:0] depth;
  logic       done, err;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rpn_engine #(.WIDTH(4), .DEPTH(5)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_din   (stk_din),
    .stk_dout  (sdout),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .result    (result),
    .carry     (carry),
    .depth     (depth),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  // Stack model: pop shows old top on data_out next cycle, push writes on the edge
  logic [3:0] mem [0:7];
  logic [2:0] sp;
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sp    <= 3'd0;
      sdout <= 4'd0;
    end else if (stk_pop && sp != 3'd0) begin
      sdout <= mem[sp - 3'd1];
      sp    <= sp - 3'd1;
    end else if (stk_push && sp != 3'd5) begin
      mem[sp] <= stk_din;
      sp      <= sp + 3'd1;
    end
  end
  assign stk_empty = (sp == 3'd0);
  assign stk_full  = (sp == 3'd5);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] d, output int lat,
                       output logic got_done, output logic got_err,
                       output int npush, output int npop);
    int cyc;
    cyc = 0;
    while (!cmd_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0; got_done = 1'b0; got_err = 1'b0; npush = 0; npop = 0;
    for (int i = 1; i <= 20 && !got_done && !got_err; i++) begin
      npush += int'(stk_push);
      npop  += int'(stk_pop);
      if (done) begin got_done = 1'b1; lat = i; end
      if (err)  begin got_err  = 1'b1; lat = i; end
      @(posedge clk); #1;
    end
    cyc = 0;
    while (!cmd_ready && cyc < 20) begin
      npush += int'(stk_push);
      npop  += int'(stk_pop);
      @(posedge clk); #1; cyc++;
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [3:0] d;
    logic [3:0] res;
    logic       c;
    int         dep;
    logic       e;
    logic [1:0] code;
    int         lat;
    int         npush;
    int         npop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [2:0] op, logic [3:0] d, logic [3:0] res, logic c, int dep,
                              logic e, logic [1:0] code, int lat, int np, int npp);
    vec_t v;
    v.op = op; v.d = d; v.res = res; v.c = c; v.dep = dep; v.e = e; v.code = code;
    v.lat = lat; v.npush = np; v.npop = npp;
    return v;
  endfunction

  initial begin
    int lat, np, npp, acc;
    logic gd, ge;

    // add with carry, then drop
    tbl.push_back(mk(OP_PUSH, 4'd9, 4'd9,  1'b0, 1, 1'b0, ERR_NONE, 1, 1, 0));
    tbl.push_back(mk(OP_PUSH, 4'd8, 4'd8,  1'b0, 2, 1'b0, ERR_NONE, 1, 1, 0));
    tbl.push_back(mk(OP_ADD,  4'd0, 4'd1,  1'b1, 1, 1'b0, ERR_NONE, 4, 1, 2));
    tbl.push_back(mk(OP_DROP, 4'd0, 4'd1,  1'b1, 0, 1'b0, ERR_NONE, 1, 0, 1));
    // operand order and borrow, then logic ops keep carry
    tbl.push_back(mk(OP_PUSH, 4'd3, 4'd3,  1'b1, 1, 1'b0, ERR_NONE, 1, 1, 0));
    tbl.push_back(mk(OP_PUSH, 4'd5, 4'd5,  1'b1, 2, 1'b0, ERR_NONE, 1, 1, 0));
    tbl.push_back(mk(OP_SUB,  4'd0, 4'd14, 1'b1, 1, 1'b0, ERR_NONE, 4, 1, 2));
    tbl.push_back(mk(OP_PUSH, 4'd2, 4'd2,  1'b1, 2, 1'b0, ERR_NONE, 1, 1, 0));
    tbl.push_back(mk(OP_XOR,  4'd0, 4'd12, 1'b1, 1, 1'b0, ERR_NONE, 4, 1, 2));
    tbl.push_back(mk(OP_PUSH, 4'd7, 4'd7,  1'b1, 2, 1'b0, ERR_NONE, 1, 1, 0));
    tbl.push_back(mk(OP_AND,  4'd0, 4'd4,  1'b1, 1, 1'b0, ERR_NONE, 4, 1, 2));
    tbl.push_back(mk(OP_PUSH, 4'd3, 4'd3,  1'b1, 2, 1'b0, ERR_NONE, 1, 1, 0));
    tbl.push_back(mk(OP_SUB,  4'd0, 4'd1,  1'b0, 1, 1'b0, ERR_NONE, 4, 1, 2));
    tbl.push_back(mk(OP_PUSH, 4'd6, 4'd6,  1'b0, 2, 1'b0, ERR_NONE, 1, 1, 0));
    tbl.push_back(mk(OP_OR,   4'd0, 4'd7,  1'b0, 1, 1'b0, ERR_NONE, 4, 1, 2));
    // underflow cases and empty clear
    tbl.push_back(mk(OP_ADD,  4'd0, 4'd7,  1'b0, 1, 1'b1, ERR_UNF,  1, 0, 0));
    tbl.push_back(mk(OP_DROP, 4'd0, 4'd7,  1'b0, 0, 1'b0, ERR_NONE, 1, 0, 1));
    tbl.push_back(mk(OP_DROP, 4'd0, 4'd7,  1'b0, 0, 1'b1, ERR_UNF,  1, 0, 0));
    tbl.push_back(mk(OP_CLEAR,4'd0, 4'd7,  1'b0, 0, 1'b0, ERR_NONE, 1, 0, 0));
    tbl.push_back(mk(OP_SUB,  4'd0, 4'd7,  1'b0, 0, 1'b1, ERR_UNF,  1, 0, 0));
    // fill, overflow, full clear
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(OP_PUSH, 4'(i), 4'(i), 1'b0, i, 1'b0, ERR_NONE, 1, 1, 0));
    tbl.push_back(mk(OP_PUSH, 4'd6, 4'd5,  1'b0, 5, 1'b1, ERR_OVF,  1, 0, 0));
    tbl.push_back(mk(OP_CLEAR,4'd0, 4'd5,  1'b0, 0, 1'b0, ERR_NONE, 5, 0, 5));
    // wrap-around add
    tbl.push_back(mk(OP_PUSH, 4'd15,4'd15, 1'b0, 1, 1'b0, ERR_NONE, 1, 1, 0));
    tbl.push_back(mk(OP_PUSH, 4'd1, 4'd1,  1'b0, 2, 1'b0, ERR_NONE, 1, 1, 0));
    tbl.push_back(mk(OP_ADD,  4'd0, 4'd0,  1'b1, 1, 1'b0, ERR_NONE, 4, 1, 2));

    rstN = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 4'd0;
    #12;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_push", stk_push, 0);
    chk("rst_pop", stk_pop, 0);
    chk("rst_din", stk_din, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry, 0);
    chk("rst_depth", depth, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    @(negedge clk); rstN = 1'b1;
    acc = 0;
    repeat (4) begin @(posedge clk); #1; acc += int'(stk_push) + int'(stk_pop); end
    chk("idle_no_strobes", acc, 0);

    foreach (tbl[k]) begin
      issue(tbl[k].op, tbl[k].d, lat, gd, ge, np, npp);
      chk($sformatf("v%0d_result", k), result, tbl[k].res);
      chk($sformatf("v%0d_carry", k), carry, tbl[k].c);
      chk($sformatf("v%0d_depth", k), depth, tbl[k].dep);
      chk($sformatf("v%0d_stack_fill", k), sp, tbl[k].dep);
      chk($sformatf("v%0d_err", k), ge, tbl[k].e);
      chk($sformatf("v%0d_done", k), gd, !tbl[k].e);
      chk($sformatf("v%0d_err_code", k), err_code, tbl[k].code);
      chk($sformatf("v%0d_latency", k), lat, tbl[k].lat);
      chk($sformatf("v%0d_pushes", k), np, tbl[k].npush);
      chk($sformatf("v%0d_pops", k), npp, tbl[k].npop);
      if (tbl[k].npush > 0 && sp != 3'd0)
        chk($sformatf("v%0d_stack_top", k), mem[sp - 3'd1], tbl[k].res);
    end

    // throughput: PUSH back-to-back gives ready again two cycles after accept
    cmd_valid = 1'b1; cmd_op = OP_PUSH; cmd_data = 4'd4;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("tp_ready_low", cmd_ready, 0);
    @(posedge clk); #1;
    chk("tp_ready_back", cmd_ready, 1);

    // reset during POP_A aborts the add
    issue(OP_PUSH, 4'd4, lat, gd, ge, np, npp);
    chk("mid_pre_depth", depth, 3);
    cmd_valid = 1'b1; cmd_op = OP_ADD;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_popa_pop", stk_pop, 1);
    rstN = 1'b0; #1;
    chk("mid_rst_pop", stk_pop, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_depth", depth, 0);
    @(negedge clk); rstN = 1'b1;
    acc = 0;
    repeat (4) begin @(posedge clk); #1; acc += int'(stk_push) + int'(stk_pop) + int'(done); end
    chk("mid_quiet", acc, 0);
    issue(OP_PUSH, 4'd14, lat, gd, ge, np, npp);
    chk("mid_push_result", result, 14);
    chk("mid_push_depth", depth, 1);
    chk("mid_push_latency", lat, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
